// File: rtl/mon_pre.sv
// Pre-processing stage for mon_exp: checks operands, finds the bit lengths of n and e,
// and converts M and 1 into the Montgomery domain by k modular doublings.
module mon_pre #(
  parameter int bitLen = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [bitLen-1:0] M,
  input  logic [bitLen-1:0] n,
  input  logic [bitLen-1:0] e,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [bitLen-1:0] M_bar,
  output logic [bitLen-1:0] x_bar,
  output logic [IDX_W-1:0]  e_idx,
  output logic [IDX_W-1:0]  mp_count
);

  typedef enum logic [2:0] {IDLE, CHECK, SCAN, CONV, DONE} state_t;

  state_t state, state_nx;

  logic [bitLen-1:0] n_r, e_r, m_r, x_r;
  logic [bitLen-1:0] m_nx, x_nx;
  logic [bitLen-1:0] n_sh, e_sh;
  logic [IDX_W-1:0]  bit_cnt, step_cnt, k_nx;
  logic              n_found, e_found, err_r;
  logic              bad_op, n_hit, e_hit;

  // One modular doubling; v < nn < 2^(bitLen-1) keeps the result below nn without wrap.
  function automatic logic [bitLen-1:0] dbl_mod(input logic [bitLen-1:0] v,
                                                input logic [bitLen-1:0] nn);
    logic [bitLen:0] t;
    t = {v, 1'b0};
    if (t >= {1'b0, nn}) t = t - {1'b0, nn};
    return t[bitLen-1:0];
  endfunction

  assign bad_op = !n_r[0] || (n_r < bitLen'(3)) || n_r[bitLen-1] || (m_r >= n_r);
  assign n_sh   = n_r >> bit_cnt;
  assign e_sh   = e_r >> bit_cnt;
  assign n_hit  = !n_found && n_sh[0];
  assign e_hit  = !e_found && e_sh[0];
  assign k_nx   = n_hit ? bit_cnt + IDX_W'(1) : mp_count;
  assign x_nx   = dbl_mod(x_r, n_r);
  assign m_nx   = dbl_mod(m_r, n_r);

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = CHECK;
      CHECK:      state_nx = bad_op ? DONE : SCAN;
      SCAN:       if (bit_cnt == '0) state_nx = CONV;
      CONV:       if (step_cnt == IDX_W'(1)) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CHECK) || (state == SCAN) || (state == CONV);
    done = (state == DONE);
    err  = err_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r      <= '0;
      e_r      <= '0;
      m_r      <= '0;
      x_r      <= '0;
      bit_cnt  <= '0;
      step_cnt <= '0;
      n_found  <= 1'b0;
      e_found  <= 1'b0;
      err_r    <= 1'b0;
      M_bar    <= '0;
      x_bar    <= '0;
      e_idx    <= '0;
      mp_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          n_r      <= n;
          e_r      <= e;
          m_r      <= M;
          err_r    <= 1'b0;
          n_found  <= 1'b0;
          e_found  <= 1'b0;
          M_bar    <= '0;
          x_bar    <= '0;
          e_idx    <= '0;
          mp_count <= '0;
        end
        CHECK: begin
          if (bad_op) err_r   <= 1'b1;
          else        bit_cnt <= IDX_W'(bitLen - 1);
        end
        SCAN: begin
          // Only the first set bit seen from the top is recorded.
          if (n_hit) begin
            n_found  <= 1'b1;
            mp_count <= bit_cnt + IDX_W'(1);
          end
          if (e_hit) begin
            e_found <= 1'b1;
            e_idx   <= bit_cnt;
          end
          bit_cnt <= bit_cnt - IDX_W'(1);
          if (bit_cnt == '0) begin
            x_r      <= bitLen'(1);
            step_cnt <= k_nx;
          end
        end
        CONV: begin
          x_r      <= x_nx;
          m_r      <= m_nx;
          step_cnt <= step_cnt - IDX_W'(1);
          if (step_cnt == IDX_W'(1)) begin
            x_bar <= x_nx;
            M_bar <= m_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_pre.sv
// Self-checking bench for mon_pre at bitLen = 16: directed table, restart/reset sequences,
// and randomized operands compared against an arithmetic reference model.
module tb_mon_pre;
  localparam int BL = 16;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BL-1:0] m_i = '0, n_i = '0, e_i = '0;
  logic          busy, done, err;
  logic [BL-1:0] M_bar, x_bar;
  logic [IW-1:0] e_idx, mp_count;

  int vectors = 0;
  int miscompares = 0;

  mon_pre #(.bitLen(BL), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .M(m_i), .n(n_i), .e(e_i),
    .busy(busy), .done(done), .err(err), .M_bar(M_bar), .x_bar(x_bar),
    .e_idx(e_idx), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned n, m, e;
    int unsigned lat, er, k, xb, mb, ei;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected results straight from the arithmetic definitions.
  function automatic vec_t ref_model(input int unsigned nv, mv, ev);
    vec_t r;
    longint p;
    r.n = nv; r.m = mv; r.e = ev;
    r.k = 0; r.xb = 0; r.mb = 0; r.ei = 0;
    r.er = ((nv % 2) == 0 || nv < 3 || nv >= 32768 || mv >= nv) ? 1 : 0;
    if (r.er != 0) begin
      r.lat = 1;
      return r;
    end
    while ((64'd1 << r.k) <= nv) r.k++;
    p    = longint'(1) << r.k;
    r.xb = int'(p % nv);
    r.mb = int'((longint'(mv) * p) % nv);
    for (int i = 0; i < BL; i++) if (((ev >> i) & 1) != 0) r.ei = i;
    r.lat = BL + r.k + 1;
    return r;
  endfunction

  task automatic accept(input int unsigned nv, mv, ev);
    @(negedge clk);
    n_i = BL'(nv); m_i = BL'(mv); e_i = BL'(ev); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_results(input string tag, input vec_t v, input int lat);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " err"}, err, v.er);
    check({tag, " mp_count"}, mp_count, v.k);
    check({tag, " x_bar"}, x_bar, v.xb);
    check({tag, " M_bar"}, M_bar, v.mb);
    check({tag, " e_idx"}, e_idx, v.ei);
    check({tag, " busy_end"}, busy, 0);
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int lat;
    lat = 0;
    accept(v.n, v.m, v.e);
    check({tag, " busy_accept"}, busy, 1);
    check({tag, " done_accept"}, done, 0);
    wait_done(lat);
    check_results(tag, v, lat);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " M_bar"}, M_bar, 0);
    check({tag, " x_bar"}, x_bar, 0);
    check({tag, " e_idx"}, e_idx, 0);
    check({tag, " mp_count"}, mp_count, 0);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v, v2;
    int lat;

    tbl[0] = '{n:589,   m:311,   e:300,     lat:27, er:0, k:10, xb:435, mb:404,   ei:8};
    tbl[1] = '{n:13,    m:5,     e:1,       lat:21, er:0, k:4,  xb:3,   mb:2,     ei:0};
    tbl[2] = '{n:588,   m:311,   e:300,     lat:1,  er:1, k:0,  xb:0,   mb:0,     ei:0};
    tbl[3] = '{n:589,   m:600,   e:300,     lat:1,  er:1, k:0,  xb:0,   mb:0,     ei:0};
    tbl[4] = '{n:32769, m:5,     e:300,     lat:1,  er:1, k:0,  xb:0,   mb:0,     ei:0};
    tbl[5] = '{n:3,     m:0,     e:0,       lat:19, er:0, k:2,  xb:1,   mb:0,     ei:0};
    tbl[6] = '{n:32767, m:32766, e:32768,   lat:32, er:0, k:15, xb:1,   mb:32766, ei:15};

    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) run_case($sformatf("tbl%0d", i), tbl[i]);

    // start while busy (mid-CONV) must not disturb the running conversion
    lat = 0;
    accept(589, 311, 300);
    repeat (19) begin @(posedge clk); #1; lat++; end
    n_i = 13; m_i = 5; e_i = 1; start = 1'b1;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    wait_done(lat);
    check_results("restart_busy", tbl[0], lat);
    repeat (4) @(posedge clk);
    #1 check("done_hold", done, 1);
    check("M_bar_hold", M_bar, 404);

    // start from DONE: done drops right after accept, new result after full latency
    run_case("restart_done", tbl[1]);

    // asynchronous reset in the middle of SCAN
    accept(589, 311, 300);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_scan");
    @(negedge clk) rst_n = 1'b1;
    run_case("after_reset", tbl[0]);

    for (int i = 0; i < 40; i++) begin
      int unsigned nv, mv, ev, mode;
      nv   = $urandom_range(1, 16383) * 2 + 1;
      mv   = $urandom_range(0, nv - 1);
      ev   = $urandom_range(0, 65535);
      mode = $urandom_range(0, 9);
      case (mode)
        0: mv = $urandom_range(nv, 65535);
        1: nv = nv ^ 1;
        2: nv = nv | 32768;
        3: ev = 0;
        default: ;
      endcase
      v = ref_model(nv, mv, ev);
      run_case($sformatf("rnd%0d", i), v);
    end

    v2 = ref_model(589, 311, 300);
    check("model_sanity_xb", v2.xb, tbl[0].xb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
